// File: rtl/referee_1_if.sv
// Bundle of the four class-FIFO read ports and the output-FIFO write port
// seen by the referee_1 merge arbiter.
interface referee_1_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  empty_0, empty_1, empty_2, empty_3;
  logic [DATA_WIDTH-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic                  almost_full;
  logic                  pop_0, pop_1, pop_2, pop_3;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            grant;
  logic                  idle;

  modport master (
    input  empty_0, empty_1, empty_2, empty_3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  almost_full,
    output pop_0, pop_1, pop_2, pop_3,
    output push, data_out, grant, idle
  );

  modport slave (
    output empty_0, empty_1, empty_2, empty_3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output almost_full,
    input  pop_0, pop_1, pop_2, pop_3,
    input  push, data_out, grant, idle
  );
endinterface

// File: rtl/referee_1.sv
// Four-to-one round-robin merge arbiter with bounded bursts, draining FWFT
// class FIFOs into one output FIFO under almost_full backpressure.
module referee_1 #(
  parameter int DATA_WIDTH = 12,
  parameter int BURST      = 4
) (
  input  logic        clk,
  input  logic        reset,
  referee_1_if.master bus
);

  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  logic [3:0]            eligible;
  logic [DATA_WIDTH-1:0] head [4];
  logic [1:0]            owner;
  logic [3:0]            burst_cnt;
  logic                  owned;
  logic                  push_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  arb_en;
  logic                  keep;
  logic [1:0]            winner;
  logic                  found;
  logic [1:0]            idx;
  logic [3:0]            pop_vec;

  assign eligible = {~bus.empty_3, ~bus.empty_2, ~bus.empty_1, ~bus.empty_0};
  assign head[0]  = bus.data_in_0;
  assign head[1]  = bus.data_in_1;
  assign head[2]  = bus.data_in_2;
  assign head[3]  = bus.data_in_3;

  // Pops are gated by reset as well, since they are purely combinational.
  assign arb_en = reset && !bus.almost_full && (eligible != 4'b0000);

  // The owner keeps the grant only after a real grant; right after reset
  // owner=3 is just the scan origin, so the first grant goes to channel 0.
  assign keep = owned && eligible[owner] && (burst_cnt < BURST_LAST);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    idx    = owner;
    for (int k = 1; k <= 4; k++) begin
      idx = owner + 2'(k);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    if (keep) winner = owner;
  end

  always_comb begin
    pop_vec = 4'b0000;
    if (arb_en) pop_vec = 4'b0001 << winner;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_q    <= 1'b0;
      data_q    <= '0;
      owner     <= 2'd3;
      burst_cnt <= 4'd0;
      owned     <= 1'b0;
    end else if (arb_en) begin
      push_q    <= 1'b1;
      data_q    <= head[winner];
      owner     <= winner;
      burst_cnt <= keep ? burst_cnt + 4'd1 : 4'd0;
      owned     <= 1'b1;
    end else begin
      push_q    <= 1'b0;
    end
  end

  assign bus.pop_0    = pop_vec[0];
  assign bus.pop_1    = pop_vec[1];
  assign bus.pop_2    = pop_vec[2];
  assign bus.pop_3    = pop_vec[3];
  assign bus.push     = push_q;
  assign bus.data_out = data_q;
  assign bus.grant    = owner;
  assign bus.idle     = (eligible == 4'b0000) && !push_q;

endmodule

// File: tb/tb_referee_1.sv
// Directed bench for referee_1: FWFT FIFO models feed the arbiter and a
// scoreboard queue holds the words expected on the output push stream.
module tb_referee_1;

  logic clk;
  logic reset;

  referee_1_if #(.DATA_WIDTH(12)) bus ();

  referee_1 #(.DATA_WIDTH(12), .BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] fmem [4][64];
  int          fhead [4];
  int          ftail [4];
  int          serial = 0;

  logic [11:0] sb [$];
  logic        exp_push;
  logic [1:0]  exp_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] head_word(input int ch);
    return (fhead[ch] != ftail[ch]) ? fmem[ch][fhead[ch]] : 12'h000;
  endfunction

  function automatic logic all_empty();
    return (fhead[0] == ftail[0]) && (fhead[1] == ftail[1]) &&
           (fhead[2] == ftail[2]) && (fhead[3] == ftail[3]);
  endfunction

  task automatic fill(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[ch][ftail[ch]] = 12'((ch << 8) | (serial & 8'hff));
      ftail[ch]++;
      serial++;
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      fhead[c] = 0;
      ftail[c] = 0;
    end
  endtask

  task automatic drive();
    bus.empty_0   = (fhead[0] == ftail[0]);
    bus.empty_1   = (fhead[1] == ftail[1]);
    bus.empty_2   = (fhead[2] == ftail[2]);
    bus.empty_3   = (fhead[3] == ftail[3]);
    bus.data_in_0 = head_word(0);
    bus.data_in_1 = head_word(1);
    bus.data_in_2 = head_word(2);
    bus.data_in_3 = head_word(3);
  endtask

  // One clock cycle, entered and left at the falling edge. exp_pop = -1
  // means no pop is expected this cycle.
  task automatic tick(input int exp_pop);
    logic [3:0]  exp_vec;
    logic [11:0] exp_word;
    drive();
    #1;
    if (exp_push) begin
      exp_word = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
      check("push", bus.push, 1);
      check("data_out", bus.data_out, exp_word);
      check("grant", bus.grant, exp_grant);
    end else begin
      check("push", bus.push, 0);
    end
    exp_vec = (exp_pop >= 0) ? 4'(1 << exp_pop) : 4'b0000;
    check("pop", {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0}, exp_vec);
    check("idle", bus.idle, all_empty() && !exp_push);
    if (exp_pop >= 0) sb.push_back(head_word(exp_pop));
    @(posedge clk);
    #1;
    if (exp_pop >= 0) begin
      fhead[exp_pop]++;
      exp_grant = 2'(exp_pop);
    end
    exp_push = (exp_pop >= 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.almost_full = 1'b0;
    reset = 1'b0;
    clear_model();
    sb.delete();
    exp_push  = 1'b0;
    exp_grant = 2'd3;
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rot [17]   = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    int resume [9] = '{0, 0, 1, 1, 1, 1, 3, 3, 0};
    int midb [9]   = '{1, 1, 3, 3, 3, 3, 1, 1, 3};

    // Reset state with every FIFO non-empty.
    reset = 1'b0;
    bus.almost_full = 1'b0;
    exp_push  = 1'b0;
    exp_grant = 2'd3;
    clear_model();
    for (int c = 0; c < 4; c++) fill(c, 6);
    drive();
    @(negedge clk);
    #1;
    check("rst_pop", {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0}, 4'b0000);
    check("rst_push", bus.push, 0);
    check("rst_data_out", bus.data_out, 12'h000);
    check("rst_grant", bus.grant, 2'd3);
    check("rst_idle", bus.idle, 0);
    #1;
    reset = 1'b1;

    // Burst rotation with all channels loaded.
    foreach (rot[i]) tick(rot[i]);
    bus.almost_full = 1'b1;
    tick(-1);

    // Backpressure mid-stream; ch3 fills in the same cycle almost_full rises.
    do_reset();
    fill(0, 8);
    fill(1, 4);
    tick(0);
    tick(0);
    bus.almost_full = 1'b1;
    fill(3, 2);
    tick(-1);
    tick(-1);
    tick(-1);
    bus.almost_full = 1'b0;
    foreach (resume[i]) tick(resume[i]);
    bus.almost_full = 1'b1;
    tick(-1);

    // Sole channel: no bubbles across the burst boundary.
    do_reset();
    fill(2, 10);
    for (int i = 0; i < 10; i++) tick(2);
    tick(-1);
    tick(-1);

    // Owner empties mid-burst; VC1 refills once VC3 has taken over.
    do_reset();
    fill(1, 2);
    fill(3, 5);
    foreach (midb[i]) begin
      tick(midb[i]);
      if (i == 2) fill(1, 2);
    end
    tick(-1);
    tick(-1);

    // Asynchronous reset between edges with a push in flight.
    do_reset();
    fill(2, 4);
    tick(2);
    tick(2);
    #2;
    reset = 1'b0;
    #1;
    check("async_push", bus.push, 0);
    check("async_data_out", bus.data_out, 12'h000);
    check("async_grant", bus.grant, 2'd3);
    check("async_pop", {bus.pop_3, bus.pop_2, bus.pop_1, bus.pop_0}, 4'b0000);
    sb.delete();
    exp_push  = 1'b0;
    exp_grant = 2'd3;
    fill(1, 2);
    fill(3, 2);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    tick(1);
    tick(2);
    tick(2);
    tick(3);
    tick(3);
    tick(-1);
    tick(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
